gpio_serial_cmd_rx: RTL and testbench
=====================================

// Module: gpio_serial_cmd_rx
// PURPOSE
//   Serial command receiver sitting directly upstream of the 4-bit GPIO output register.
//   Deserialises 8-bit SPI-style frames (SCLK/MOSI/SS_N, mode 0, MSB first) and checks a header.
//   Each good frame produces one registered write: Addr, Value, and a one-CLK CS strobe,
//   which drive the GPIO block's Addr/Value/CS inputs directly.
// PARAMETERS
//   SYNC_STAGES     2      flops per async input synchroniser (>=2)
//   HEADER          3'b101 required value of frame bits [7:5]
//   TIMEOUT_CYCLES  1024   CLK cycles without SCLK rise (SS_N low, mid-frame) before abort
// PORTS
//   CLK       in   1  system clock; all logic on posedge
//   RST       in   1  synchronous, active-high reset
//   SCLK      in   1  serial clock, async to CLK
//   MOSI      in   1  serial data, async, sampled at synchronised SCLK rise
//   SS_N      in   1  frame select, active low, async
//   Addr      out  2  GPIO bit index of last accepted frame
//   Value     out  1  GPIO bit value of last accepted frame
//   CS        out  1  one-cycle write strobe, one per accepted frame
//   Err       out  1  one-cycle pulse on header, short-frame or timeout error
//   Busy      out  1  high while state != IDLE
//   FrameCnt  out  8  accepted-frame count, wraps 255->0
// BEHAVIOUR
//   Reset (RST=1 at posedge): Addr=0, Value=0, CS=0, Err=0, Busy=0, FrameCnt=0.
//     State=IDLE; shift reg, bit count, timer = 0.
//     SS_N sync flops reset to 1; SCLK/MOSI sync flops reset to 0.
//     RST mid-frame discards the partial frame; it raises no Err.
//   Input sync: SYNC_STAGES flops each, then one extra SCLK flop for edge detect.
//     sclk_rise = sclk_s & ~sclk_d.
//     SCLK high and low each >= SYNC_STAGES+1 CLK periods; faster SCLK is unsupported.
//   Frame bits: [7:5]=header, [4:3]=reserved (ignored), [2:1]=Addr, [0]=Value.
//   FSM:
//     IDLE:  ss_s==0 -> SHIFT; clear bit count and timer.
//     SHIFT, checked in this priority:
//       1. ss_s==1 before 8 bits -> Err pulse, -> IDLE.
//       2. timer==TIMEOUT_CYCLES-1 -> Err pulse, -> WAIT.
//       3. sclk_rise -> shift in mosi_s (LSB side), bitcnt+1, timer=0; else timer+1.
//       bitcnt reaching 8 -> CHECK on the next cycle.
//     CHECK (exactly 1 cycle):
//       header ok -> next cycle Addr/Value load, CS=1 for 1 cycle, FrameCnt+1.
//       header bad -> next cycle Err=1 for 1 cycle; Addr/Value/FrameCnt unchanged.
//       Always -> WAIT.
//     WAIT:  ignore SCLK/MOSI (extra bits dropped); ss_s==1 -> IDLE.
//   Latency: CS rises 2 CLK cycles after the cycle in which the 8th sclk_rise is detected.
//   CS and Err are never high in the same cycle. CS never asserts twice per SS_N low period.
//   SS_N rising in the same cycle as the 8th sclk_rise: the bit counts, frame is accepted.
//   Addr/Value hold their values between strobes. Busy is combinational from state.
// TESTING
//   1. Apply RST 3 cycles -> all outputs 0; Busy=0.
//   2. Frame 8'b101_00_10_1 -> exactly one CS pulse, Addr=2'b10, Value=1, FrameCnt=1.
//      Err=0 throughout.
//   3. Frame 8'b110_00_01_1 -> one Err pulse, CS stays 0, Addr/Value/FrameCnt unchanged.
//   4. SS_N high after 5 bits -> one Err pulse, Busy falls.
//      Then frame 8'b101_11_11_0 -> CS, Addr=3, Value=0 (reserved bits ignored).
//   5. 12-bit burst starting 8'b101_00_01_1 -> one CS, Addr=1, Value=1; trailing 4 bits ignored.
//      Then SCLK stalled 1100 cycles mid-frame -> Err at cycle 1024; no CS.
//   6. RST after 4 bits -> reset values, no Err.
//      Then 256 good frames -> FrameCnt wraps to 0 with 256 CS pulses.

Source files
------------

// File: rtl/gpio_serial_cmd_rx.sv
// ============================================================================
// Module      : gpio_serial_cmd_rx
// Description : Mode-0 serial frame receiver that turns each 8-bit command
//               (header / reserved / addr / value) into one GPIO write strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_serial_cmd_rx #(
   parameter int         SYNC_STAGES    = 2,
   parameter logic [2:0] HEADER         = 3'b101,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCLK,
   input  logic       MOSI,
   input  logic       SS_N,
   output logic [1:0] Addr,
   output logic       Value,
   output logic       CS,
   output logic       Err,
   output logic       Busy,
   output logic [7:0] FrameCnt
);

   localparam int                 c_TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [c_TMR_W-1:0] c_TMR_MAX = c_TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_CHECK = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_mosi_sync;
   logic [SYNC_STAGES-1:0] r_ss_sync;
   logic                   r_sclk_d;

   state_t               r_state, w_state_nxt;
   logic [7:0]           r_shift, w_shift_nxt;
   logic [3:0]           r_bitcnt, w_bitcnt_nxt;
   logic [c_TMR_W-1:0]   r_timer, w_timer_nxt;
   logic                 w_cs_set, w_err_set;

   logic [1:0]           r_addr;
   logic                 r_value;
   logic                 r_cs;
   logic                 r_err;
   logic [7:0]           r_frame_cnt;

   logic                 w_sclk_s, w_mosi_s, w_ss_s;
   logic                 w_sclk_rise;
   logic                 w_last_bit;

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
   assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
   assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
   // The 8th edge wins over a simultaneous deselect so the frame still counts.
   assign w_last_bit  = w_sclk_rise && (r_bitcnt == 4'd7);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
         r_ss_sync   <= '1;
         r_sclk_d    <= 1'b0;
      end else begin
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
         r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], SS_N};
         r_sclk_d    <= w_sclk_s;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_shift_nxt  = r_shift;
      w_bitcnt_nxt = r_bitcnt;
      w_timer_nxt  = r_timer;
      w_cs_set     = 1'b0;
      w_err_set    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_ss_s) begin
               w_state_nxt  = S_SHIFT;
               w_bitcnt_nxt = '0;
               w_timer_nxt  = '0;
            end
         end
         S_SHIFT: begin
            if (w_ss_s && !w_last_bit) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_timer == c_TMR_MAX) begin
               w_err_set   = 1'b1;
               w_state_nxt = S_WAIT;
            end else if (w_sclk_rise) begin
               w_shift_nxt  = {r_shift[6:0], w_mosi_s};
               w_bitcnt_nxt = r_bitcnt + 4'd1;
               w_timer_nxt  = '0;
               if (w_last_bit) begin
                  w_state_nxt = S_CHECK;
               end
            end else begin
               w_timer_nxt = r_timer + c_TMR_W'(1);
            end
         end
         S_CHECK: begin
            if (r_shift[7:5] == HEADER) begin
               w_cs_set = 1'b1;
            end else begin
               w_err_set = 1'b1;
            end
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_ss_s) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_shift     <= '0;
         r_bitcnt    <= '0;
         r_timer     <= '0;
         r_addr      <= '0;
         r_value     <= 1'b0;
         r_cs        <= 1'b0;
         r_err       <= 1'b0;
         r_frame_cnt <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_shift  <= w_shift_nxt;
         r_bitcnt <= w_bitcnt_nxt;
         r_timer  <= w_timer_nxt;
         r_cs     <= w_cs_set;
         r_err    <= w_err_set;
         if (w_cs_set) begin
            r_addr      <= r_shift[2:1];
            r_value     <= r_shift[0];
            r_frame_cnt <= r_frame_cnt + 8'd1;
         end
      end
   end

   assign Addr     = r_addr;
   assign Value    = r_value;
   assign CS       = r_cs;
   assign Err      = r_err;
   assign FrameCnt = r_frame_cnt;
   assign Busy     = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_gpio_serial_cmd_rx.sv
// ============================================================================
// Module      : tb_gpio_serial_cmd_rx
// Description : Self-checking bench for gpio_serial_cmd_rx with a frame-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_serial_cmd_rx;

   localparam int         HALF = 4;
   localparam logic [2:0] HDR  = 3'b101;

   logic       CLK  = 1'b0;
   logic       RST  = 1'b1;
   logic       SCLK = 1'b0;
   logic       MOSI = 1'b0;
   logic       SS_N = 1'b1;
   logic [1:0] Addr;
   logic       Value;
   logic       CS;
   logic       Err;
   logic       Busy;
   logic [7:0] FrameCnt;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc = 0, cs_cnt = 0, err_cnt = 0, overlap = 0, last_err_cyc = 0, rise_cyc = 0;

   logic [1:0] m_addr  = 2'b00;
   logic       m_value = 1'b0;
   int         m_cnt   = 0;

   gpio_serial_cmd_rx dut (
      .CLK      (CLK),
      .RST      (RST),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .SS_N     (SS_N),
      .Addr     (Addr),
      .Value    (Value),
      .CS       (CS),
      .Err      (Err),
      .Busy     (Busy),
      .FrameCnt (FrameCnt)
   );

   initial forever #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      if (!RST) begin
         if (CS) cs_cnt++;
         if (Err) begin
            err_cnt++;
            last_err_cyc = cyc;
         end
         if (CS && Err) overlap++;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, got running, want finished");
      $fatal(1, "watchdog");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge CLK);
   endtask

   // Frame bit i is data[15-i]; optional deselect coincident with the last rise.
   task automatic send_frame(input logic [15:0] data, input int n,
                             input bit ss_with_last, input bit raise_ss);
      SS_N = 1'b0;
      wait_clks(4);
      for (int i = 0; i < n; i++) begin
         MOSI = data[15-i];
         wait_clks(HALF);
         SCLK = 1'b1;
         rise_cyc = cyc;
         if (ss_with_last && i == n - 1) SS_N = 1'b1;
         wait_clks(HALF);
         SCLK = 1'b0;
      end
      if (raise_ss) begin
         if (!ss_with_last) begin
            wait_clks(HALF);
            SS_N = 1'b1;
         end
         wait_clks(12);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      wait_clks(3);
      n_checks++; if (Addr !== 2'b00)     begin n_fail++; $display("FAIL reset_addr got %b want 00", Addr); end
      n_checks++; if (Value !== 1'b0)     begin n_fail++; $display("FAIL reset_value got %b want 0", Value); end
      n_checks++; if (CS !== 1'b0)        begin n_fail++; $display("FAIL reset_cs got %b want 0", CS); end
      n_checks++; if (Err !== 1'b0)       begin n_fail++; $display("FAIL reset_err got %b want 0", Err); end
      n_checks++; if (Busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", Busy); end
      n_checks++; if (FrameCnt !== 8'd0)  begin n_fail++; $display("FAIL reset_framecnt got %0d want 0", FrameCnt); end
      RST = 1'b0;
      wait_clks(4);
   endtask

   task automatic test_good_frame();
      int c0, e0;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_00_10_1, 8'h00}, 8, 1'b0, 1'b1);
      m_addr = 2'b10; m_value = 1'b1; m_cnt = (m_cnt + 1) % 256;
      n_checks++; if (cs_cnt - c0 !== 1)   begin n_fail++; $display("FAIL good_cs_pulses got %0d want 1", cs_cnt - c0); end
      n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL good_err_pulses got %0d want 0", err_cnt - e0); end
      n_checks++; if (Addr !== m_addr)     begin n_fail++; $display("FAIL good_addr got %b want %b", Addr, m_addr); end
      n_checks++; if (Value !== m_value)   begin n_fail++; $display("FAIL good_value got %b want %b", Value, m_value); end
      n_checks++; if (FrameCnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL good_framecnt got %0d want %0d", FrameCnt, m_cnt); end
   endtask

   task automatic test_bad_header();
      int c0, e0;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b110_00_01_1, 8'h00}, 8, 1'b0, 1'b1);
      n_checks++; if (cs_cnt - c0 !== 0)   begin n_fail++; $display("FAIL badhdr_cs_pulses got %0d want 0", cs_cnt - c0); end
      n_checks++; if (err_cnt - e0 !== 1)  begin n_fail++; $display("FAIL badhdr_err_pulses got %0d want 1", err_cnt - e0); end
      n_checks++; if (Addr !== m_addr)     begin n_fail++; $display("FAIL badhdr_addr got %b want %b", Addr, m_addr); end
      n_checks++; if (Value !== m_value)   begin n_fail++; $display("FAIL badhdr_value got %b want %b", Value, m_value); end
      n_checks++; if (FrameCnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL badhdr_framecnt got %0d want %0d", FrameCnt, m_cnt); end
   endtask

   task automatic test_short_then_reserved();
      int c0, e0;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_00_10_1, 8'h00}, 5, 1'b0, 1'b1);
      n_checks++; if (err_cnt - e0 !== 1)  begin n_fail++; $display("FAIL short_err_pulses got %0d want 1", err_cnt - e0); end
      n_checks++; if (cs_cnt - c0 !== 0)   begin n_fail++; $display("FAIL short_cs_pulses got %0d want 0", cs_cnt - c0); end
      n_checks++; if (Busy !== 1'b0)       begin n_fail++; $display("FAIL short_busy got %b want 0", Busy); end
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_11_11_0, 8'h00}, 8, 1'b0, 1'b1);
      m_addr = 2'b11; m_value = 1'b0; m_cnt = (m_cnt + 1) % 256;
      n_checks++; if (cs_cnt - c0 !== 1)   begin n_fail++; $display("FAIL rsvd_cs_pulses got %0d want 1", cs_cnt - c0); end
      n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL rsvd_err_pulses got %0d want 0", err_cnt - e0); end
      n_checks++; if (Addr !== m_addr)     begin n_fail++; $display("FAIL rsvd_addr got %b want %b", Addr, m_addr); end
      n_checks++; if (Value !== m_value)   begin n_fail++; $display("FAIL rsvd_value got %b want %b", Value, m_value); end
   endtask

   task automatic test_long_burst();
      int c0, e0;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_00_01_1, 4'b1011, 4'h0}, 12, 1'b0, 1'b1);
      m_addr = 2'b01; m_value = 1'b1; m_cnt = (m_cnt + 1) % 256;
      n_checks++; if (cs_cnt - c0 !== 1)   begin n_fail++; $display("FAIL burst_cs_pulses got %0d want 1", cs_cnt - c0); end
      n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL burst_err_pulses got %0d want 0", err_cnt - e0); end
      n_checks++; if (Addr !== m_addr)     begin n_fail++; $display("FAIL burst_addr got %b want %b", Addr, m_addr); end
      n_checks++; if (Value !== m_value)   begin n_fail++; $display("FAIL burst_value got %b want %b", Value, m_value); end
      n_checks++; if (FrameCnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL burst_framecnt got %0d want %0d", FrameCnt, m_cnt); end
   endtask

   task automatic test_timeout();
      int c0, e0, lat, k;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_00_01_1, 8'h00}, 3, 1'b0, 1'b0);
      k = 0;
      while (k < 1100 && err_cnt == e0) begin
         wait_clks(1);
         k++;
      end
      lat = last_err_cyc - rise_cyc;
      n_checks++; if (err_cnt - e0 !== 1)  begin n_fail++; $display("FAIL timeout_err_pulses got %0d want 1", err_cnt - e0); end
      // Edge detect lands 2 cycles after the drive, then 1024 idle cycles to the abort.
      n_checks++; if (lat < 1020 || lat > 1035) begin n_fail++; $display("FAIL timeout_latency got %0d want 1020..1035", lat); end
      n_checks++; if (Busy !== 1'b1)       begin n_fail++; $display("FAIL timeout_busy_wait got %b want 1", Busy); end
      wait_clks(1100 - k);
      SS_N = 1'b1;
      wait_clks(12);
      n_checks++; if (err_cnt - e0 !== 1)  begin n_fail++; $display("FAIL timeout_err_total got %0d want 1", err_cnt - e0); end
      n_checks++; if (cs_cnt - c0 !== 0)   begin n_fail++; $display("FAIL timeout_cs_pulses got %0d want 0", cs_cnt - c0); end
      n_checks++; if (Busy !== 1'b0)       begin n_fail++; $display("FAIL timeout_busy_idle got %b want 0", Busy); end
   endtask

   task automatic test_ss_with_last_bit();
      int c0, e0;
      c0 = cs_cnt; e0 = err_cnt;
      send_frame({8'b101_01_00_1, 8'h00}, 8, 1'b1, 1'b1);
      m_addr = 2'b00; m_value = 1'b1; m_cnt = (m_cnt + 1) % 256;
      n_checks++; if (cs_cnt - c0 !== 1)   begin n_fail++; $display("FAIL sslast_cs_pulses got %0d want 1", cs_cnt - c0); end
      n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL sslast_err_pulses got %0d want 0", err_cnt - e0); end
      n_checks++; if (Addr !== m_addr)     begin n_fail++; $display("FAIL sslast_addr got %b want %b", Addr, m_addr); end
   endtask

   task automatic test_random_frames();
      int c0, e0, r, n;
      bit swl, exp_cs;
      logic [7:0] d;
      for (int f = 0; f < 40; f++) begin
         c0 = cs_cnt; e0 = err_cnt;
         r = $urandom_range(0, 9);
         d = 8'($urandom);
         if ($urandom_range(0, 9) < 6) d[7:5] = HDR;
         n = 8; swl = 1'b0;
         if (r < 2)       n = $urandom_range(1, 7);
         else if (r == 2) n = $urandom_range(9, 12);
         else if (r == 3) swl = 1'b1;
         send_frame({d, 8'($urandom)}, n, swl, 1'b1);
         exp_cs = (n >= 8) && (d[7:5] == HDR);
         if (exp_cs) begin
            m_addr = d[2:1]; m_value = d[0]; m_cnt = (m_cnt + 1) % 256;
         end
         n_checks++; if (cs_cnt - c0 !== int'(exp_cs)) begin n_fail++; $display("FAIL rand_cs frame %0d d=%h n=%0d got %0d want %0d", f, d, n, cs_cnt - c0, exp_cs); end
         n_checks++; if (err_cnt - e0 !== int'(!exp_cs)) begin n_fail++; $display("FAIL rand_err frame %0d d=%h n=%0d got %0d want %0d", f, d, n, err_cnt - e0, !exp_cs); end
         n_checks++; if (Addr !== m_addr || Value !== m_value) begin n_fail++; $display("FAIL rand_data frame %0d got %b/%b want %b/%b", f, Addr, Value, m_addr, m_value); end
         n_checks++; if (FrameCnt !== 8'(m_cnt)) begin n_fail++; $display("FAIL rand_framecnt frame %0d got %0d want %0d", f, FrameCnt, m_cnt); end
         n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL rand_busy frame %0d got %b want 0", f, Busy); end
      end
   endtask

   task automatic test_reset_midframe_and_wrap();
      int c0, e0;
      logic [7:0] d;
      send_frame({8'b101_00_11_1, 8'h00}, 4, 1'b0, 1'b0);
      e0 = err_cnt;
      RST = 1'b1; SS_N = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      wait_clks(3);
      m_addr = 2'b00; m_value = 1'b0; m_cnt = 0;
      n_checks++; if (Addr !== 2'b00 || Value !== 1'b0) begin n_fail++; $display("FAIL midrst_data got %b/%b want 00/0", Addr, Value); end
      n_checks++; if (FrameCnt !== 8'd0) begin n_fail++; $display("FAIL midrst_framecnt got %0d want 0", FrameCnt); end
      n_checks++; if (Busy !== 1'b0 || CS !== 1'b0 || Err !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl got busy=%b cs=%b err=%b want 0/0/0", Busy, CS, Err); end
      RST = 1'b0;
      wait_clks(10);
      n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL midrst_err_pulses got %0d want 0", err_cnt - e0); end
      c0 = cs_cnt;
      for (int f = 0; f < 256; f++) begin
         d = 8'($urandom);
         d[7:5] = HDR;
         send_frame({d, 8'h00}, 8, 1'b0, 1'b1);
         m_addr = d[2:1]; m_value = d[0]; m_cnt = (m_cnt + 1) % 256;
         n_checks++; if (FrameCnt !== 8'(m_cnt) || Addr !== m_addr || Value !== m_value) begin n_fail++; $display("FAIL wrap_frame %0d got cnt=%0d %b/%b want cnt=%0d %b/%b", f, FrameCnt, Addr, Value, m_cnt, m_addr, m_value); end
      end
      n_checks++; if (cs_cnt - c0 !== 256) begin n_fail++; $display("FAIL wrap_cs_pulses got %0d want 256", cs_cnt - c0); end
      n_checks++; if (FrameCnt !== 8'd0)   begin n_fail++; $display("FAIL wrap_framecnt got %0d want 0", FrameCnt); end
      n_checks++; if (err_cnt - e0 !== 0)  begin n_fail++; $display("FAIL wrap_err_pulses got %0d want 0", err_cnt - e0); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_header();
      test_short_then_reserved();
      test_long_burst();
      test_timeout();
      test_ss_with_last_bit();
      test_random_frames();
      test_reset_midframe_and_wrap();
      n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL cs_err_overlap got %0d cycles want 0", overlap); end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
